// File: rtl/detect_collector_pkg.sv
// Shared definitions for the detection collector: state encoding, default
// geometry and the drop counter width.
package detect_collector_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_TW     = 32;
    localparam int DROP_W     = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Channel counts never exceed eight, so one fixed-width popcount serves all.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/detect_collector_if.sv
// Bundle of detector strobes, acknowledges and the outgoing event record.
// The slave side is the collector; the master side is detectors plus consumer.
interface detect_collector_if
    import detect_collector_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int TW     = DEF_TW
) ();

    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH*TW-1:0] ch_time;
    logic [NUM_CH-1:0]    ch_ack;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUM_CH-1:0]    out_mask;
    logic [NUM_CH*TW-1:0] out_time;
    logic [NUM_CH*TW-1:0] out_delta;
    logic                 out_partial;
    logic [DROP_W-1:0]    drop_cnt;

    modport master (
        output ch_valid, ch_time, out_ready,
        input  ch_ack, out_valid, out_mask, out_time, out_delta, out_partial, drop_cnt
    );

    modport slave (
        input  ch_valid, ch_time, out_ready,
        output ch_ack, out_valid, out_mask, out_time, out_delta, out_partial, drop_cnt
    );

endinterface

// File: rtl/detect_collector_slot.sv
// One channel of the collector: captured timestamp, presence bit, ack pulse
// and the delta against the reference time, all registered at capture.
module detect_slot #(
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture_en,
    input  logic          clear,
    input  logic [TW-1:0] ch_time,
    input  logic [TW-1:0] ref_time,
    output logic          mask,
    output logic          ack,
    output logic [TW-1:0] time_out,
    output logic [TW-1:0] delta_out
);

    logic          mask_q, mask_d;
    logic          ack_q, ack_d;
    logic [TW-1:0] time_q, time_d;
    logic [TW-1:0] delta_q, delta_d;

    // Clear beats capture so a discarded window never acknowledges anything.
    always_comb begin
        mask_d  = mask_q;
        time_d  = time_q;
        delta_d = delta_q;
        ack_d   = capture_en && !clear;
        if (clear) begin
            mask_d  = 1'b0;
            time_d  = '0;
            delta_d = '0;
        end else if (capture_en) begin
            mask_d  = 1'b1;
            time_d  = ch_time;
            delta_d = ch_time - ref_time;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q  <= 1'b0;
            ack_q   <= 1'b0;
            time_q  <= '0;
            delta_q <= '0;
        end else begin
            mask_q  <= mask_d;
            ack_q   <= ack_d;
            time_q  <= time_d;
            delta_q <= delta_d;
        end
    end

    assign mask      = mask_q;
    assign ack       = ack_q;
    assign time_out  = time_q;
    assign delta_out = delta_q;

endmodule

// File: rtl/detect_collector.sv
// Collects one timestamp per channel inside a bounded window and emits a
// single record of times, deltas to the earliest channel and a hit mask.
module detect_collector
    import detect_collector_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int TW          = DEF_TW,
    parameter int TIMEOUT_CYC = 100000,
    parameter int MIN_CH      = 2
) (
    input logic               clk,
    input logic               rst,
    detect_collector_if.slave bus
);

    localparam int              CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      MIN_CNT  = 4'(MIN_CH);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       ref_q, ref_d;
    logic                partial_q, partial_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic [NUM_CH-1:0]   capture_en;
    logic [NUM_CH-1:0]   drops;
    logic [NUM_CH-1:0]   mask;
    logic [NUM_CH-1:0]   mask_next;
    logic [NUM_CH-1:0]   ack;
    logic                clear;
    logic [TW-1:0]       ref_sel;
    logic [TW-1:0]       ref_in;
    logic [DROP_W:0]     drop_sum;
    logic [TW-1:0]       slot_time  [NUM_CH];
    logic [TW-1:0]       slot_delta [NUM_CH];

    // The lowest-index channel strobing in the opening cycle sets the reference.
    always_comb begin
        ref_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.ch_valid[i]) begin
                ref_sel = bus.ch_time[i*TW +: TW];
            end
        end
    end

    assign ref_in = (state_q == IDLE) ? ref_sel : ref_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ref_d      = ref_q;
        partial_d  = partial_q;
        capture_en = '0;
        drops      = '0;
        clear      = 1'b0;
        mask_next  = mask;

        unique case (state_q)
            IDLE: begin
                if (|bus.ch_valid) begin
                    capture_en = bus.ch_valid;
                    mask_next  = bus.ch_valid;
                    ref_d      = ref_sel;
                    cnt_d      = '0;
                    partial_d  = 1'b0;
                    state_d    = (&mask_next) ? EMIT : COLLECT;
                end
            end
            COLLECT: begin
                capture_en = bus.ch_valid & ~mask;
                drops      = bus.ch_valid & mask;
                mask_next  = mask | capture_en;
                // A mask completing on the timeout cycle still closes as full.
                if (&mask_next) begin
                    partial_d = 1'b0;
                    state_d   = EMIT;
                end else if (cnt_q == CNT_LAST) begin
                    if (popcount8(8'(mask_next)) >= MIN_CNT) begin
                        partial_d = 1'b1;
                        state_d   = EMIT;
                    end else begin
                        clear   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EMIT: begin
                drops = bus.ch_valid;
                if (bus.out_ready) begin
                    clear     = 1'b1;
                    partial_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        drop_sum = {1'b0, drop_q} + {{(DROP_W - 3){1'b0}}, popcount8(8'(drops))};
        drop_d   = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ref_q     <= '0;
            partial_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_q     <= ref_d;
            partial_q <= partial_d;
            drop_q    <= drop_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        detect_slot #(
            .TW (TW)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .capture_en (capture_en[g]),
            .clear      (clear),
            .ch_time    (bus.ch_time[g*TW +: TW]),
            .ref_time   (ref_in),
            .mask       (mask[g]),
            .ack        (ack[g]),
            .time_out   (slot_time[g]),
            .delta_out  (slot_delta[g])
        );
    end

    always_comb begin
        bus.out_time  = '0;
        bus.out_delta = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.out_time[i*TW +: TW]  = slot_time[i];
            bus.out_delta[i*TW +: TW] = slot_delta[i];
        end
    end

    assign bus.ch_ack      = ack;
    assign bus.out_mask    = mask;
    assign bus.out_valid   = (state_q == EMIT);
    assign bus.out_partial = partial_q;
    assign bus.drop_cnt    = drop_q;

endmodule

// File: tb/tb_detect_collector.sv
// Directed bench for detect_collector: full close, timeout close, discard,
// drops under stall, timestamp wrap and mid-window reset.
module tb_detect_collector;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    detect_collector_if #(.NUM_CH(4), .TW(32)) bus ();

    detect_collector #(
        .NUM_CH      (4),
        .TW          (32),
        .TIMEOUT_CYC (50),
        .MIN_CH      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.ch_valid = '0;
        repeat (n) step();
    endtask

    task automatic pulse(input logic [3:0] v, input logic [31:0] t0, input logic [31:0] t1,
                         input logic [31:0] t2, input logic [31:0] t3);
        bus.ch_valid = v;
        bus.ch_time  = {t3, t2, t1, t0};
        step();
        bus.ch_valid = '0;
    endtask

    task automatic handshake(input logic [3:0] v);
        bus.ch_valid  = v;
        bus.out_ready = 1'b1;
        step();
        bus.ch_valid  = '0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  stable;

        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b0;
        bus.ch_valid = '0;
        bus.ch_time  = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_valid", 128'(bus.out_valid), 128'(0));
        check("rst_mask",  128'(bus.out_mask),  128'(0));
        check("rst_ack",   128'(bus.ch_ack),    128'(0));
        check("rst_time",  bus.out_time,        128'(0));
        check("rst_delta", bus.out_delta,       128'(0));
        check("rst_part",  128'(bus.out_partial), 128'(0));
        check("rst_drop",  128'(bus.drop_cnt),  128'(0));
        rst = 1'b1;
        idle(10);

        $display("[TB] full four-channel burst");
        pulse(4'b0001, 32'd1000, 32'd0, 32'd0, 32'd0);
        check("t1_ack0", 128'(bus.ch_ack), 128'(4'b0001));
        idle(1);
        pulse(4'b0010, 32'd0, 32'd1003, 32'd0, 32'd0);
        check("t1_ack1", 128'(bus.ch_ack), 128'(4'b0010));
        idle(2);
        pulse(4'b0100, 32'd0, 32'd0, 32'd998, 32'd0);
        check("t1_ack2", 128'(bus.ch_ack), 128'(4'b0100));
        check("t1_notyet", 128'(bus.out_valid), 128'(0));
        idle(4);
        pulse(4'b1000, 32'd0, 32'd0, 32'd0, 32'd1010);
        check("t1_ack3",  128'(bus.ch_ack),    128'(4'b1000));
        check("t1_valid", 128'(bus.out_valid), 128'(1));
        check("t1_mask",  128'(bus.out_mask),  128'(4'hF));
        check("t1_part",  128'(bus.out_partial), 128'(0));
        check("t1_time",  bus.out_time,  {32'd1010, 32'd998, 32'd1003, 32'd1000});
        check("t1_delta", bus.out_delta, {32'd10, 32'hFFFF_FFFE, 32'd3, 32'd0});
        handshake(4'b0000);
        check("t1_release", 128'(bus.out_valid), 128'(0));
        check("t1_clear",   128'(bus.out_mask),  128'(0));
        check("t1_drop",    128'(bus.drop_cnt),  128'(0));

        $display("[TB] timeout with two channels");
        pulse(4'b0110, 32'd0, 32'd500, 32'd505, 32'd0);
        check("t2_ack", 128'(bus.ch_ack), 128'(4'b0110));
        n = 0;
        while (!bus.out_valid && n < 60) begin
            step();
            n++;
        end
        check("t2_latency", 128'(n), 128'(50));
        check("t2_mask",  128'(bus.out_mask),    128'(4'h6));
        check("t2_part",  128'(bus.out_partial), 128'(1));
        check("t2_time",  bus.out_time,  {32'd0, 32'd505, 32'd500, 32'd0});
        check("t2_delta", bus.out_delta, {32'd0, 32'd5, 32'd0, 32'd0});
        handshake(4'b0000);
        check("t2_release", 128'(bus.out_valid), 128'(0));

        $display("[TB] lone channel discarded on timeout");
        pulse(4'b1000, 32'd0, 32'd0, 32'd0, 32'd777);
        seen = 1'b0;
        for (int k = 0; k < 55; k++) begin
            step();
            if (bus.out_valid) seen = 1'b1;
        end
        check("t3_novalid", 128'(seen),         128'(0));
        check("t3_mask",    128'(bus.out_mask), 128'(0));
        check("t3_drop",    128'(bus.drop_cnt), 128'(0));

        $display("[TB] repeat strobe and consumer stall");
        pulse(4'b0001, 32'd2000, 32'd0, 32'd0, 32'd0);
        idle(1);
        pulse(4'b0001, 32'd2222, 32'd0, 32'd0, 32'd0);
        check("t4_noack", 128'(bus.ch_ack),   128'(0));
        check("t4_drop1", 128'(bus.drop_cnt), 128'(1));
        pulse(4'b1110, 32'd0, 32'd2001, 32'd2002, 32'd2003);
        check("t4_ack",   128'(bus.ch_ack),    128'(4'b1110));
        check("t4_valid", 128'(bus.out_valid), 128'(1));
        check("t4_time",  bus.out_time,  {32'd2003, 32'd2002, 32'd2001, 32'd2000});
        check("t4_delta", bus.out_delta, {32'd3, 32'd2, 32'd1, 32'd0});
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.ch_valid = (k == 5) ? 4'b0100 : 4'b0000;
            step();
            if (bus.out_valid !== 1'b1 || bus.ch_ack !== 4'b0000 || bus.out_mask !== 4'hF
                || bus.out_time !== {32'd2003, 32'd2002, 32'd2001, 32'd2000}
                || bus.out_delta !== {32'd3, 32'd2, 32'd1, 32'd0}) stable = 1'b0;
        end
        bus.ch_valid = '0;
        check("t4_stable", 128'(stable),       128'(1));
        check("t4_drop2",  128'(bus.drop_cnt), 128'(2));
        handshake(4'b0000);
        check("t4_release", 128'(bus.out_valid), 128'(0));

        $display("[TB] timestamp wrap");
        pulse(4'b0001, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0);
        idle(1);
        pulse(4'b0010, 32'd0, 32'h0000_0003, 32'd0, 32'd0);
        pulse(4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        check("t5_valid", 128'(bus.out_valid), 128'(1));
        check("t5_delta", bus.out_delta, {32'd3, 32'd1, 32'd5, 32'd0});
        handshake(4'b0000);

        $display("[TB] reset mid-collection");
        pulse(4'b0011, 32'd10, 32'd20, 32'd0, 32'd0);
        idle(2);
        rst = 1'b0;
        #1;
        check("t6_rmask",  128'(bus.out_mask),  128'(0));
        check("t6_rtime",  bus.out_time,        128'(0));
        check("t6_rdrop",  128'(bus.drop_cnt),  128'(0));
        check("t6_rvalid", 128'(bus.out_valid), 128'(0));
        step();
        check("t6_rack", 128'(bus.ch_ack), 128'(0));
        rst = 1'b1;
        idle(2);
        pulse(4'b1111, 32'd100, 32'd90, 32'd120, 32'd95);
        check("t6_ack",   128'(bus.ch_ack),    128'(4'hF));
        check("t6_valid", 128'(bus.out_valid), 128'(1));
        check("t6_time",  bus.out_time,  {32'd95, 32'd120, 32'd90, 32'd100});
        check("t6_delta", bus.out_delta, {32'hFFFF_FFFB, 32'd20, 32'hFFFF_FFF6, 32'd0});
        handshake(4'b0001);
        check("t6_hsdrop", 128'(bus.drop_cnt),  128'(1));
        check("t6_hsrel",  128'(bus.out_valid), 128'(0));
        pulse(4'b0001, 32'd55, 32'd0, 32'd0, 32'd0);
        check("t6_newack",  128'(bus.ch_ack),   128'(4'b0001));
        check("t6_newmask", 128'(bus.out_mask), 128'(4'b0001));
        idle(55);
        check("t6_discard", 128'(bus.out_mask), 128'(0));
        check("t6_drop",    128'(bus.drop_cnt), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
